// File: rtl/fp_alu_pkg.sv
// Shared FP16 ALU definitions: operand width, opmode encodings and common constants.
// Used by the arbiter and anything else that drives or decodes ALU opmodes.
package fp_alu_pkg;

  localparam int FP16_W = 16;
  localparam int OPMODE_W = 4;

  typedef logic [OPMODE_W-1:0] opmode_t;
  typedef logic [FP16_W-1:0] fp16_t;

  localparam opmode_t OP_FMA_ADD = 4'b0000;
  localparam opmode_t OP_FMA_SUB = 4'b0001;
  localparam opmode_t OP_INV_ADD = 4'b0010;
  localparam opmode_t OP_INV_SUB = 4'b0011;
  localparam opmode_t OP_LOG     = 4'b0100;
  localparam opmode_t OP_EXP     = 4'b1000;

  localparam fp16_t FP16_ONE = 16'h3C00;

endpackage

// File: rtl/fp_alu_tag_fifo.sv
// In-order FIFO holding the requester ID of every ALU operation in flight.
// Read data is first-word fall-through so a pop can use the head in the same cycle.
module fp_alu_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fp16_alu_arbiter.sv
// Round-robin front end sharing one FP16 ALU among NREQ requesters, with credit-limited
// issue and in-order routing of results back to the requester that issued them.
module fp16_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 8,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [4*NREQ-1:0]      req_opmode,
  input  logic [FP16_W*NREQ-1:0] req_a,
  input  logic [FP16_W*NREQ-1:0] req_b,
  input  logic [FP16_W*NREQ-1:0] req_c,
  output logic                   alu_in_valid,
  output logic [3:0]             alu_opmode,
  output logic [FP16_W-1:0]      alu_a,
  output logic [FP16_W-1:0]      alu_b,
  output logic [FP16_W-1:0]      alu_c,
  input  logic                   alu_out_valid,
  input  logic [FP16_W-1:0]      alu_out,
  output logic                   resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [FP16_W-1:0]      resp_data,
  output logic                   busy,
  output logic                   err_unexpected
);

  localparam int CNTW = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]   outstanding_q, outstanding_d;
  logic              alu_in_valid_q;
  opmode_t           alu_opmode_q;
  fp16_t             alu_a_q, alu_b_q, alu_c_q;
  logic              resp_valid_q;
  logic [IDW-1:0]    resp_id_q;
  fp16_t             resp_data_q;
  logic              err_q;

  logic              credit, grant_found, accept, pop;
  logic [IDW-1:0]    grant_idx, cand;
  logic [IDW-1:0]    tag_head;
  logic              tag_empty, tag_full;

  assign credit = (outstanding_q < CNTW'(MAX_OUT));

  // Walk from the highest offset down so the candidate closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((32'(rr_ptr_q) + 32'(k)) % NREQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept    = grant_found & credit & ~rst;
  assign req_ready = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign pop       = alu_out_valid & ~tag_empty;

  assign rr_ptr_d = accept ? IDW'((32'(grant_idx) + 32'd1) % NREQ) : rr_ptr_q;

  always_comb begin
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  fp_alu_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept & ~tag_full),
    .din_i   (grant_idx),
    .pop_i   (pop),
    .dout_o  (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      outstanding_q  <= '0;
      alu_in_valid_q <= 1'b0;
      alu_opmode_q   <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_c_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_data_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      outstanding_q  <= outstanding_d;
      alu_in_valid_q <= accept;
      if (accept) begin
        alu_opmode_q <= req_opmode[4*grant_idx +: 4];
        alu_a_q      <= req_a[FP16_W*grant_idx +: FP16_W];
        alu_b_q      <= req_b[FP16_W*grant_idx +: FP16_W];
        alu_c_q      <= req_c[FP16_W*grant_idx +: FP16_W];
      end
      resp_valid_q <= pop;
      if (pop) begin
        resp_id_q   <= tag_head;
        resp_data_q <= alu_out;
      end
      // A result with no matching tag is a protocol error; it stays visible until reset.
      err_q <= err_q | (alu_out_valid & tag_empty);
    end
  end

  assign alu_in_valid   = alu_in_valid_q;
  assign alu_opmode     = alu_opmode_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_c          = alu_c_q;
  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_data      = resp_data_q;
  assign busy           = (outstanding_q != '0) | alu_in_valid_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_fp16_alu_arbiter.sv
// Directed bench for fp16_alu_arbiter; the bench itself plays the ALU with hand-chosen results.
// Inputs change just after the falling edge and outputs are sampled before the next rising edge.
module tb_fp16_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_opmode;
  logic [63:0] req_a, req_b, req_c;
  logic        alu_in_valid;
  logic [3:0]  alu_opmode;
  logic [15:0] alu_a, alu_b, alu_c;
  logic        alu_out_valid;
  logic [15:0] alu_out;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_data;
  logic        busy, err_unexpected;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp16_alu_arbiter #(.NREQ(4), .MAX_OUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opmode(req_opmode),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .alu_in_valid(alu_in_valid), .alu_opmode(alu_opmode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_out_valid(alu_out_valid), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c);
    req_opmode[4*i +: 4] = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_c[16*i +: 16] = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    alu_out_valid = 1'b0;
    alu_out = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({req_ready, alu_in_valid, alu_opmode, alu_a, alu_b, alu_c} !== 57'd0) begin
      n_fail++;
      $display("FAIL reset_issue: ready=%b aiv=%b op=%h a=%h b=%h c=%h want all zero",
               req_ready, alu_in_valid, alu_opmode, alu_a, alu_b, alu_c);
    end
    n_cmp++;
    if ({resp_valid, resp_id, resp_data, busy, err_unexpected} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_resp: rv=%b id=%0d data=%h busy=%b err=%b want all zero",
               resp_valid, resp_id, resp_data, busy, err_unexpected);
    end
  endtask

  task automatic test_single_request();
    do_reset();
    set_req(2, 4'b0000, 16'h3C00, 16'h4000, 16'h3C00);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if ({alu_in_valid, alu_opmode, alu_a, alu_b, alu_c} !== {1'b1, 4'b0000, 16'h3C00, 16'h4000, 16'h3C00}) begin
      n_fail++;
      $display("FAIL single_issue: aiv=%b op=%b a=%h b=%h c=%h want 1 0000 3c00 4000 3c00",
               alu_in_valid, alu_opmode, alu_a, alu_b, alu_c);
    end
    tick();
    n_cmp++;
    if ({alu_in_valid, busy} !== 2'b01) begin
      n_fail++; $display("FAIL single_one_pulse: aiv=%b busy=%b want 0 1", alu_in_valid, busy);
    end
    alu_out_valid = 1'b1;
    alu_out = 16'h4200;  // 1.0 * 2.0 + 1.0 = 3.0
    tick();
    alu_out_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd2, 16'h4200}) begin
      n_fail++;
      $display("FAIL single_resp: rv=%b id=%0d data=%h want 1 2 4200", resp_valid, resp_id, resp_data);
    end
    tick();
    n_cmp++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_idle: rv=%b busy=%b want 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 4'b0001 << (k % 4));
      end
      if (k > 0) begin
        n_cmp++;
        if ({alu_in_valid, alu_a} !== {1'b1, 16'h1000 + 16'((k - 1) % 4)}) begin
          n_fail++;
          $display("FAIL rr_issue[%0d]: aiv=%b a=%h want 1 %h", k, alu_in_valid, alu_a,
                   16'h1000 + 16'((k - 1) % 4));
        end
      end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      alu_out_valid = 1'b1;
      alu_out = 16'hA000 + 16'(k);
      tick();
      n_cmp++;
      if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'(k % 4), 16'hA000 + 16'(k)}) begin
        n_fail++;
        $display("FAIL rr_resp[%0d]: rv=%b id=%0d data=%h want 1 %0d %h", k, resp_valid, resp_id,
                 resp_data, k % 4, 16'hA000 + 16'(k));
      end
    end
    alu_out_valid = 1'b0;
    tick();
    n_cmp++;
    if ({busy, err_unexpected} !== 2'b00) begin
      n_fail++; $display("FAIL rr_drained: busy=%b err=%b want 0 0", busy, err_unexpected);
    end
  endtask

  task automatic test_credit_limit();
    int accepts;
    do_reset();
    req_valid = 4'b1111;
    accepts = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (req_ready != 4'b0000) accepts++;
      tick();
    end
    n_cmp++;
    if (accepts !== 8) begin
      n_fail++; $display("FAIL credit_accepts: got %0d want 8", accepts);
    end
    // Pop with outstanding at the limit: no same-cycle grant.
    alu_out_valid = 1'b1;
    alu_out = 16'h5555;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL credit_no_bypass: got %b want 0000", req_ready);
    end
    tick();
    alu_out_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL credit_after_pop: got %b want 0001", req_ready);
    end
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd0, 16'h5555}) begin
      n_fail++;
      $display("FAIL credit_resp: rv=%b id=%0d data=%h want 1 0 5555", resp_valid, resp_id, resp_data);
    end
    tick();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL credit_full_again: got %b want 0000", req_ready);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    int accepts;
    do_reset();
    set_req(0, 4'b0100, 16'h3C00, 16'h0000, 16'h0000);
    req_valid = 4'b0001;
    tick();
    tick();
    tick();
    alu_out_valid = 1'b1;
    alu_out = 16'h0000;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL pp_grant: got %b want 0001", req_ready);
    end
    tick();
    alu_out_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, alu_in_valid} !== {1'b1, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL pp_resp: rv=%b id=%0d aiv=%b want 1 0 1", resp_valid, resp_id, alu_in_valid);
    end
    // Outstanding should still be 3, leaving room for exactly five more.
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (req_ready != 4'b0000) accepts++;
      tick();
    end
    n_cmp++;
    if (accepts !== 5) begin
      n_fail++; $display("FAIL pp_remaining_credit: got %0d want 5", accepts);
    end
  endtask

  task automatic test_spurious_result();
    do_reset();
    alu_out_valid = 1'b1;
    alu_out = 16'h1234;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++;
    if ({err_unexpected, resp_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL spur_flag: err=%b rv=%b busy=%b want 1 0 0", err_unexpected, resp_valid, busy);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if ({err_unexpected, resp_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL spur_sticky: err=%b rv=%b busy=%b want 1 0 0", err_unexpected, resp_valid, busy);
    end
    set_req(3, 4'b1000, 16'h3C00, 16'h0000, 16'h0000);
    req_valid = 4'b1000;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL spur_grant: got %b want 1000", req_ready);
    end
    tick();
    req_valid = '0;
    alu_out_valid = 1'b1;
    alu_out = 16'h4170;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data, err_unexpected} !== {1'b1, 2'd3, 16'h4170, 1'b1}) begin
      n_fail++;
      $display("FAIL spur_followup: rv=%b id=%0d data=%h err=%b want 1 3 4170 1",
               resp_valid, resp_id, resp_data, err_unexpected);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL spur_no_underflow: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'b0001, 16'h4000 + 16'(i), 16'h4400, 16'h4800);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ready_low: got %b want 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = 4'b0010;
    n_cmp++;
    if ({alu_in_valid, alu_opmode, alu_a, alu_b, alu_c, resp_valid, resp_id, resp_data, busy, err_unexpected}
        !== 78'd0) begin
      n_fail++;
      $display("FAIL rst_outputs: aiv=%b op=%h a=%h b=%h c=%h rv=%b id=%0d data=%h busy=%b err=%b want all zero",
               alu_in_valid, alu_opmode, alu_a, alu_b, alu_c, resp_valid, resp_id, resp_data, busy,
               err_unexpected);
    end
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rst_regrant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if ({alu_in_valid, alu_a} !== {1'b1, 16'h4001}) begin
      n_fail++; $display("FAIL rst_issue: aiv=%b a=%h want 1 4001", alu_in_valid, alu_a);
    end
    alu_out_valid = 1'b1;
    alu_out = 16'hC400;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data, err_unexpected} !== {1'b1, 2'd1, 16'hC400, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_resp: rv=%b id=%0d data=%h err=%b want 1 1 c400 0",
               resp_valid, resp_id, resp_data, err_unexpected);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_opmode = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    alu_out_valid = 1'b0;
    alu_out = '0;
    test_reset();
    test_single_request();
    test_round_robin();
    test_credit_limit();
    test_push_pop_same_cycle();
    test_spurious_result();
    test_reset_mid_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
